// File: rtl/freq_meter_if.sv
// Bundle of the freq_meter measurement controls and results.
// The master drives the stimulus and request lines; the slave side is the meter itself.
interface freq_meter_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 sig_in;
    logic                 start;
    logic                 cont;
    logic                 busy;
    logic                 valid;
    logic [CNT_WIDTH-1:0] freq_count;
    logic                 overflow;

    modport master (
        output sig_in,
        output start,
        output cont,
        input  busy,
        input  valid,
        input  freq_count,
        input  overflow
    );

    modport slave (
        input  sig_in,
        input  start,
        input  cont,
        output busy,
        output valid,
        output freq_count,
        output overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES clk cycles and reports the count with a one-cycle valid pulse.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic         i_clk,
    input logic         i_rst_n,
    freq_meter_if.slave bus
);
    localparam int unsigned          GateW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GateW-1:0]     GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StDone
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_s_d;
    logic                 w_s;
    logic                 w_edge;
    logic [GateW-1:0]     r_gate_cnt;
    logic [GateW-1:0]     w_gate_cnt_next;
    logic [CNT_WIDTH-1:0] r_edge_cnt;
    logic [CNT_WIDTH-1:0] w_edge_cnt_next;
    logic                 r_sat;
    logic                 w_sat_next;
    logic                 w_gate_last;
    logic [CNT_WIDTH-1:0] r_freq_count;
    logic                 r_overflow;

    // Input path runs in every state so entering MEASURE never sees a stale edge.
    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_edge = w_s & ~r_s_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_gate_cnt <= w_gate_cnt_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_sat      <= w_sat_next;
        end
    end

    // Counters are cleared in every state except MEASURE.
    always_comb begin
        w_state_next    = r_state;
        w_gate_cnt_next = '0;
        w_edge_cnt_next = '0;
        w_sat_next      = 1'b0;
        w_gate_last     = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.start || bus.cont) begin
                    w_state_next = StMeasure;
                end
            end
            StMeasure: begin
                w_gate_cnt_next = r_gate_cnt + GateW'(1);
                w_edge_cnt_next = r_edge_cnt;
                w_sat_next      = r_sat;
                if (w_edge) begin
                    if (r_edge_cnt == CntMax) begin
                        w_sat_next = 1'b1;
                    end else begin
                        w_edge_cnt_next = r_edge_cnt + CNT_WIDTH'(1);
                    end
                end
                if (r_gate_cnt == GateLast) begin
                    w_gate_last  = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = bus.cont ? StMeasure : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Capture the final count (including a last-cycle edge) so it is visible with valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_freq_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_gate_last) begin
            r_freq_count <= w_edge_cnt_next;
            r_overflow   <= w_sat_next;
        end
    end

    assign bus.busy       = (r_state != StIdle);
    assign bus.valid      = (r_state == StDone);
    assign bus.freq_count = r_freq_count;
    assign bus.overflow   = r_overflow;
endmodule
